// File: rtl/reqack_mon_pkg.sv
// Shared types, widths and helpers for the request/acknowledge protocol monitor.
package reqack_mon_pkg;

    localparam int unsigned ERR_CODE_W = 3;
    localparam int unsigned MAX_CH     = 32;
    localparam int unsigned POP_W      = 6;   // holds a popcount of up to MAX_CH bits

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_DATA      = 2'd2,
        ST_WAIT_DONE = 2'd3
    } ch_state_e;

    typedef enum logic [ERR_CODE_W-1:0] {
        ERR_NONE         = 3'd0,
        ERR_ACK_TIMEOUT  = 3'd1,
        ERR_DATA_MISSING = 3'd2,
        ERR_DONE_TIMEOUT = 3'd3,
        ERR_SPURIOUS     = 3'd4
    } err_code_e;

    // Bits needed for a counter running 0..n-1 (never less than one bit).
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // One counter is shared by the ack-latency, beat and done-latency phases.
    function automatic int unsigned phase_cnt_w(input int unsigned ack_lat,
                                                input int unsigned beats,
                                                input int unsigned done_lat);
        int unsigned w;
        w = cnt_w(ack_lat);
        if (cnt_w(beats) > w)    w = cnt_w(beats);
        if (cnt_w(done_lat) > w) w = cnt_w(done_lat);
        return w;
    endfunction

    // Number of set bits in a channel vector.
    function automatic logic [POP_W-1:0] popcount(input logic [MAX_CH-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/reqack_mon_ch.sv
// One channel of the request/acknowledge monitor: phase FSM, shared phase
// counter and registered error / completion pulses.
// With REQACK_PROTOCOL_MONITOR_ASSERT_EN defined, an SVA property and a cover
// on good completions are added; outputs are the same in both builds.
module reqack_mon_ch
    import reqack_mon_pkg::*;
#(
    parameter int unsigned MAX_ACK_LAT  = 1,
    parameter int unsigned DATA_BEATS   = 1,
    parameter int unsigned MAX_DONE_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  request,
    input  logic                  acknowledge,
    input  logic                  data_enable,
    input  logic                  done,
    output logic                  busy,
    output logic                  err_valid,
    output logic [ERR_CODE_W-1:0] err_code,
    output logic                  txn_done,
    output logic                  err_c,
    output logic                  txn_c
);

    localparam int unsigned CNT_W = phase_cnt_w(MAX_ACK_LAT, DATA_BEATS, MAX_DONE_LAT);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(MAX_ACK_LAT - 1);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(DATA_BEATS - 1);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(MAX_DONE_LAT - 1);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    err_code_e        code_c;

    // Next state, counter and per-edge error / completion detection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_c  = ERR_NONE;
        txn_c   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acknowledge || data_enable || done) begin
                    code_c = ERR_SPURIOUS;
                end
                if (request) begin
                    state_d = ST_WAIT_ACK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_ACK: begin
                if (acknowledge) begin
                    state_d = ST_DATA;
                    cnt_d   = '0;
                end else if (cnt_q == ACK_LAST) begin
                    code_c  = ERR_ACK_TIMEOUT;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (!data_enable) begin
                    code_c  = ERR_DATA_MISSING;
                    state_d = ST_IDLE;
                end else if (cnt_q == BEAT_LAST) begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (done) begin
                    txn_c   = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == DONE_LAST) begin
                    code_c  = ERR_DONE_TIMEOUT;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign err_c = (code_c != ERR_NONE);

    // State register and registered status pulses; reset reports nothing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            busy      <= 1'b0;
            err_valid <= 1'b0;
            err_code  <= ERR_NONE;
            txn_done  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy      <= (state_d != ST_IDLE);
            err_valid <= err_c;
            err_code  <= code_c;
            txn_done  <= txn_c;
        end
    end

`ifdef REQACK_PROTOCOL_MONITOR_ASSERT_EN
    // Full handshake expected from every accepted request.
    property p_handshake;
        @(posedge clk) disable iff (!rst_n)
            (state_q == ST_IDLE && request) |->
                ##[1:MAX_ACK_LAT] acknowledge ##1 data_enable [*DATA_BEATS]
                ##[1:MAX_DONE_LAT] done;
    endproperty

    a_handshake: assert property (p_handshake)
        else $error("%m: handshake violation");

    a_no_error: assert property (@(posedge clk) disable iff (!rst_n) !err_c)
        else $error("%m: protocol error code %0d", code_c);

    c_good_txn: cover property (@(posedge clk) disable iff (!rst_n) txn_c);
`endif

endmodule

// File: rtl/reqack_protocol_monitor.sv
// Multi-channel passive request/acknowledge/data_enable/done protocol monitor.
// Optional macro REQACK_PROTOCOL_MONITOR_ASSERT_EN adds per-channel SVA checks.
module reqack_protocol_monitor
    import reqack_mon_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned MAX_ACK_LAT  = 1,
    parameter int unsigned DATA_BEATS   = 1,
    parameter int unsigned MAX_DONE_LAT = 1,
    parameter int unsigned ERR_CNT_W    = 8,
    parameter int unsigned TXN_CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            request,
    input  logic [NUM_CH-1:0]            acknowledge,
    input  logic [NUM_CH-1:0]            data_enable,
    input  logic [NUM_CH-1:0]            done,
    input  logic                         clr_err,
    output logic [NUM_CH-1:0]            busy,
    output logic [NUM_CH-1:0]            err_valid,
    output logic [NUM_CH*ERR_CODE_W-1:0] err_code,
    output logic [ERR_CNT_W-1:0]         err_count,
    output logic [NUM_CH-1:0]            txn_done,
    output logic [TXN_CNT_W-1:0]         txn_count
);

    // Elaboration-time parameter legality.
    if (NUM_CH < 1 || NUM_CH > MAX_CH) begin : g_bad_num_ch
        $error("reqack_protocol_monitor: NUM_CH=%0d outside 1..32", NUM_CH);
    end
    if (MAX_ACK_LAT < 1) begin : g_bad_ack_lat
        $error("reqack_protocol_monitor: MAX_ACK_LAT must be >= 1");
    end
    if (DATA_BEATS < 1) begin : g_bad_beats
        $error("reqack_protocol_monitor: DATA_BEATS must be >= 1");
    end
    if (MAX_DONE_LAT < 1) begin : g_bad_done_lat
        $error("reqack_protocol_monitor: MAX_DONE_LAT must be >= 1");
    end
    if (ERR_CNT_W < 1 || TXN_CNT_W < 1) begin : g_bad_cnt_w
        $error("reqack_protocol_monitor: counter widths must be >= 1");
    end

    localparam int unsigned ERR_SUM_W = ERR_CNT_W + POP_W;
    localparam logic [ERR_SUM_W-1:0] ERR_MAX = ERR_SUM_W'({ERR_CNT_W{1'b1}});

    logic [NUM_CH-1:0]    err_c;
    logic [NUM_CH-1:0]    txn_c;
    logic [POP_W-1:0]     err_pop_c;
    logic [POP_W-1:0]     txn_pop_c;
    logic [ERR_CNT_W-1:0] err_base_c;
    logic [ERR_SUM_W-1:0] err_sum_c;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        reqack_mon_ch #(
            .MAX_ACK_LAT  (MAX_ACK_LAT),
            .DATA_BEATS   (DATA_BEATS),
            .MAX_DONE_LAT (MAX_DONE_LAT)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .request     (request[i]),
            .acknowledge (acknowledge[i]),
            .data_enable (data_enable[i]),
            .done        (done[i]),
            .busy        (busy[i]),
            .err_valid   (err_valid[i]),
            .err_code    (err_code[i*ERR_CODE_W +: ERR_CODE_W]),
            .txn_done    (txn_done[i]),
            .err_c       (err_c[i]),
            .txn_c       (txn_c[i])
        );
    end

    // Per-edge event counts; a clear drops the old total before adding.
    always_comb begin
        err_pop_c  = popcount(MAX_CH'(err_c));
        txn_pop_c  = popcount(MAX_CH'(txn_c));
        err_base_c = clr_err ? '0 : err_count;
        err_sum_c  = ERR_SUM_W'(err_base_c) + ERR_SUM_W'(err_pop_c);
    end

    // Saturating error total and wrapping completion total.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_count <= '0;
            txn_count <= '0;
        end else begin
            err_count <= (err_sum_c > ERR_MAX) ? '1 : err_sum_c[ERR_CNT_W-1:0];
            txn_count <= txn_count + TXN_CNT_W'(txn_pop_c);
        end
    end

endmodule

// File: tb/tb_reqack_protocol_monitor.sv
// Bench for reqack_protocol_monitor: a default instance and a stretched-timing
// instance share stimulus and are compared against a timestamp-based model.
module tb_reqack_protocol_monitor;

    localparam int unsigned NCH = 4;

    logic             clk;
    logic             rst_n;
    logic             clr_err;
    logic [NCH-1:0]   request, acknowledge, data_enable, done;

    logic [NCH-1:0]   busy_a, ev_a, txn_a;
    logic [3*NCH-1:0] code_a;
    logic [7:0]       errc_a;
    logic [15:0]      txnc_a;

    logic [NCH-1:0]   busy_b, ev_b, txn_b;
    logic [3*NCH-1:0] code_b;
    logic [7:0]       errc_b;
    logic [2:0]       txnc_b;

    reqack_protocol_monitor dut_a (
        .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
        .data_enable(data_enable), .done(done), .clr_err(clr_err),
        .busy(busy_a), .err_valid(ev_a), .err_code(code_a), .err_count(errc_a),
        .txn_done(txn_a), .txn_count(txnc_a)
    );

    reqack_protocol_monitor #(
        .NUM_CH(4), .MAX_ACK_LAT(4), .DATA_BEATS(3), .MAX_DONE_LAT(2),
        .ERR_CNT_W(8), .TXN_CNT_W(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .request(request), .acknowledge(acknowledge),
        .data_enable(data_enable), .done(done), .clr_err(clr_err),
        .busy(busy_b), .err_valid(ev_b), .err_code(code_b), .err_count(errc_b),
        .txn_done(txn_b), .txn_count(txnc_b)
    );

    always #5 clk = ~clk;

    // Model configuration per instance: [0] = dut_a, [1] = dut_b.
    int ml[2] = '{1, 4};
    int db[2] = '{1, 3};
    int md[2] = '{1, 2};
    int tw[2] = '{16, 3};

    // A channel is either idle or in a phase that began at time t0.
    typedef struct {
        bit active;
        int phase;   // 0 awaiting ack, 1 collecting beats, 2 awaiting done
        int t0;
    } mch_t;

    mch_t             ms[2][NCH];
    int unsigned      m_errc[2];
    int unsigned      m_txnc[2];
    logic [NCH-1:0]   e_busy[2], e_ev[2], e_txn[2];
    logic [3*NCH-1:0] e_code[2];

    int cyc_n    = 0;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", tag, cyc_n, got, exp);
        end
    endtask

    // Apply the protocol rules to the inputs sampled at this edge.
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            int pe;
            int pt;
            pe = 0;
            pt = 0;
            if (!rst_n) begin
                for (int ch = 0; ch < NCH; ch++) ms[k][ch].active = 1'b0;
                e_busy[k] = '0; e_ev[k] = '0; e_txn[k] = '0; e_code[k] = '0;
                m_errc[k] = 0;  m_txnc[k] = 0;
            end else begin
                for (int ch = 0; ch < NCH; ch++) begin
                    int code;
                    int age;
                    bit ok;
                    code = 0;
                    ok   = 1'b0;
                    age  = cyc_n - ms[k][ch].t0;
                    if (!ms[k][ch].active) begin
                        if (acknowledge[ch] || data_enable[ch] || done[ch]) code = 4;
                        if (request[ch]) begin
                            ms[k][ch].active = 1'b1;
                            ms[k][ch].phase  = 0;
                            ms[k][ch].t0     = cyc_n;
                        end
                    end else if (ms[k][ch].phase == 0) begin
                        if (acknowledge[ch]) begin
                            ms[k][ch].phase = 1;
                            ms[k][ch].t0    = cyc_n;
                        end else if (age >= ml[k]) begin
                            code = 1;
                            ms[k][ch].active = 1'b0;
                        end
                    end else if (ms[k][ch].phase == 1) begin
                        if (!data_enable[ch]) begin
                            code = 2;
                            ms[k][ch].active = 1'b0;
                        end else if (age >= db[k]) begin
                            ms[k][ch].phase = 2;
                            ms[k][ch].t0    = cyc_n;
                        end
                    end else begin
                        if (done[ch]) begin
                            ok = 1'b1;
                            ms[k][ch].active = 1'b0;
                        end else if (age >= md[k]) begin
                            code = 3;
                            ms[k][ch].active = 1'b0;
                        end
                    end
                    e_busy[k][ch]       = ms[k][ch].active;
                    e_ev[k][ch]         = (code != 0);
                    e_txn[k][ch]        = ok;
                    e_code[k][ch*3 +: 3] = 3'(code);
                    if (code != 0) pe++;
                    if (ok) pt++;
                end
                m_errc[k] = (clr_err ? 32'd0 : m_errc[k]) + 32'(pe);
                if (m_errc[k] > 255) m_errc[k] = 255;
                m_txnc[k] = (m_txnc[k] + 32'(pt)) % (32'd1 << tw[k]);
            end
        end
    endtask

    task automatic compare_all();
        check("a_busy",      32'(busy_a), 32'(e_busy[0]));
        check("a_err_valid", 32'(ev_a),   32'(e_ev[0]));
        check("a_err_code",  32'(code_a), 32'(e_code[0]));
        check("a_txn_done",  32'(txn_a),  32'(e_txn[0]));
        check("a_err_count", 32'(errc_a), m_errc[0]);
        check("a_txn_count", 32'(txnc_a), m_txnc[0]);
        check("b_busy",      32'(busy_b), 32'(e_busy[1]));
        check("b_err_valid", 32'(ev_b),   32'(e_ev[1]));
        check("b_err_code",  32'(code_b), 32'(e_code[1]));
        check("b_txn_done",  32'(txn_b),  32'(e_txn[1]));
        check("b_err_count", 32'(errc_b), m_errc[1]);
        check("b_txn_count", 32'(txnc_b), m_txnc[1]);
    endtask

    // Drive one cycle of inputs, advance one edge, check after the edge.
    task automatic step(input logic [NCH-1:0] r, input logic [NCH-1:0] a,
                        input logic [NCH-1:0] d, input logic [NCH-1:0] n,
                        input logic clr, input logic rstn);
        request     = r;
        acknowledge = a;
        data_enable = d;
        done        = n;
        clr_err     = clr;
        rst_n       = rstn;
        @(posedge clk);
        cyc_n++;
        model_update();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        step('0, '0, '0, '0, 1'b0, 1'b0);
        step('0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [NCH-1:0] r, a, d, n;
        clk = 1'b0;
        request = '0; acknowledge = '0; data_enable = '0; done = '0;
        clr_err = 1'b0; rst_n = 1'b0;

        // Reset state
        do_reset();
        check("rst_busy_a",  32'(busy_a), 32'd0);
        check("rst_errc_b",  32'(errc_b), 32'd0);
        check("rst_txnc_a",  32'(txnc_a), 32'd0);

        // Legal default-timing transaction on channel 0
        step(4'b0001, '0, '0, '0, 1'b0, 1'b1);
        step('0, 4'b0001, '0, '0, 1'b0, 1'b1);
        step('0, '0, 4'b0001, '0, 1'b0, 1'b1);
        check("legal_busy_a", 32'(busy_a[0]), 32'd1);
        step('0, '0, '0, 4'b0001, 1'b0, 1'b1);
        check("legal_txn_done_a", 32'(txn_a[0]), 32'd1);
        check("legal_txn_cnt_a",  32'(txnc_a), 32'd1);
        check("legal_errv_a",     32'(ev_a), 32'd0);
        check("legal_busy_off_a", 32'(busy_a[0]), 32'd0);

        // Acknowledge timeout at the last accepted edge (MAX_ACK_LAT=4)
        do_reset();
        step(4'b0001, '0, '0, '0, 1'b0, 1'b1);
        repeat (3) step('0, '0, '0, '0, 1'b0, 1'b1);
        check("acklat_busy_b", 32'(busy_b[0]), 32'd1);
        check("acklat_errv_b", 32'(ev_b[0]), 32'd0);
        step('0, '0, '0, '0, 1'b0, 1'b1);
        check("ackto_errv_b", 32'(ev_b[0]), 32'd1);
        check("ackto_code_b", 32'(code_b[2:0]), 32'd1);
        check("ackto_busy_b", 32'(busy_b[0]), 32'd0);
        check("ackto_errc_b", 32'(errc_b), 32'd1);

        // Missing middle beat (DATA_BEATS=3), then late strobes are spurious
        do_reset();
        step(4'b0001, '0, '0, '0, 1'b0, 1'b1);
        step('0, 4'b0001, '0, '0, 1'b0, 1'b1);
        step('0, '0, 4'b0001, '0, 1'b0, 1'b1);
        step('0, '0, '0, '0, 1'b0, 1'b1);
        check("dmiss_code_b", 32'(code_b[2:0]), 32'd2);
        check("dmiss_errv_b", 32'(ev_b[0]), 32'd1);
        step('0, '0, 4'b0001, '0, 1'b0, 1'b1);
        step('0, '0, '0, 4'b0001, 1'b0, 1'b1);
        check("late_done_code_b", 32'(code_b[2:0]), 32'd4);

        // Error counter saturation
        do_reset();
        repeat (63) step('0, 4'b1111, '0, '0, 1'b0, 1'b1);
        step('0, 4'b0011, '0, '0, 1'b0, 1'b1);
        check("sat_pre_b", 32'(errc_b), 32'd254);
        step(4'b0110, '0, '0, '0, 1'b0, 1'b1);
        repeat (4) step('0, '0, '0, '0, 1'b0, 1'b1);
        check("sat_two_to_b", 32'(ev_b), 32'b0110);
        check("sat_hit_b", 32'(errc_b), 32'd255);
        step('0, 4'b1111, '0, '0, 1'b0, 1'b1);
        check("sat_hold_b", 32'(errc_b), 32'd255);

        // Reset in the middle of a transaction on channel 3
        do_reset();
        step(4'b1000, '0, '0, '0, 1'b0, 1'b1);
        step('0, 4'b1000, '0, '0, 1'b0, 1'b1);
        step('0, '0, 4'b1000, '0, 1'b0, 1'b1);
        step('0, '0, '0, '0, 1'b0, 1'b0);
        check("midrst_busy_b", 32'(busy_b), 32'd0);
        check("midrst_errv_b", 32'(ev_b), 32'd0);
        check("midrst_errc_b", 32'(errc_b), 32'd0);
        repeat (5) step('0, '0, '0, '0, 1'b0, 1'b1);
        check("postrst_errc_b", 32'(errc_b), 32'd0);
        check("postrst_errc_a", 32'(errc_a), 32'd0);

        // Clear coinciding with a new spurious error
        do_reset();
        step('0, 4'b1111, '0, '0, 1'b0, 1'b1);
        step('0, 4'b0111, '0, '0, 1'b0, 1'b1);
        check("clr_pre_b", 32'(errc_b), 32'd7);
        step('0, '0, '0, 4'b0100, 1'b1, 1'b1);
        check("clr_code_b", 32'(code_b[8:6]), 32'd4);
        check("clr_errc_b", 32'(errc_b), 32'd1);
        check("clr_errc_a", 32'(errc_a), 32'd1);

        // Randomised traffic biased towards legal handshakes of dut_b
        do_reset();
        for (int it = 0; it < 3000; it++) begin
            r = '0; a = '0; d = '0; n = '0;
            for (int ch = 0; ch < NCH; ch++) begin
                if (!ms[1][ch].active) begin
                    r[ch] = ($urandom_range(99) < 30);
                    a[ch] = ($urandom_range(99) < 4);
                    d[ch] = ($urandom_range(99) < 4);
                    n[ch] = ($urandom_range(99) < 4);
                end else begin
                    r[ch] = ($urandom_range(99) < 15);
                    a[ch] = ($urandom_range(99) < 5);
                    d[ch] = ($urandom_range(99) < 5);
                    n[ch] = ($urandom_range(99) < 5);
                    case (ms[1][ch].phase)
                        0:       a[ch] = ($urandom_range(99) < 35);
                        1:       d[ch] = ($urandom_range(99) < 90);
                        default: n[ch] = ($urandom_range(99) < 45);
                    endcase
                end
            end
            step(r, a, d, n, ($urandom_range(99) < 3), ($urandom_range(199) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
